lsu_mem_port: RTL and testbench



---
 rtl/lsu_mem_port.sv | 141 ++++++++++++++
 tb/tb_lsu_mem_port.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_port.sv
// Load/store unit bridging the execute stage to one port of a byte-enabled,
// synchronous-read data RAM: one request in flight, faults never touch memory.
module lsu_mem_port (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_waddr,
    output logic [31:0] mem_raddr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {IDLE, LD_ADDR, LD_DATA, ST, RESP} state_t;

    state_t      state, state_nxt;
    logic        accept;
    logic        req_fault;
    logic [2:0]  funct3_q;
    logic [1:0]  ofs_q;

    function automatic logic is_fault(input logic we, input logic [2:0] f3,
                                      input logic [1:0] a);
        case (f3)
            3'b000:  is_fault = 1'b0;
            3'b001:  is_fault = a[0];
            3'b010:  is_fault = (a != 2'b00);
            3'b100:  is_fault = we;
            3'b101:  is_fault = we | a[0];
            default: is_fault = 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] store_be(input logic [1:0] sz, input logic [1:0] a);
        case (sz)
            2'b00:   store_be = 4'b0001 << a;
            2'b01:   store_be = a[1] ? 4'b1100 : 4'b0011;
            default: store_be = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [1:0] sz, input logic [31:0] d);
        case (sz)
            2'b00:   store_data = {4{d[7:0]}};
            2'b01:   store_data = {2{d[15:0]}};
            default: store_data = d;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] a,
                                                 input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        b = rd[{a, 3'b000} +: 8];
        h = rd[{a[1], 4'b0000} +: 16];
        case (f3)
            3'b000:  load_extract = {{24{b[7]}}, b};
            3'b100:  load_extract = {24'h0, b};
            3'b001:  load_extract = {{16{h[15]}}, h};
            3'b101:  load_extract = {16'h0, h};
            default: load_extract = rd;
        endcase
    endfunction

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign accept     = req_valid && req_ready;
    assign req_fault  = is_fault(req_we, req_funct3, req_addr[1:0]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_fault)   state_nxt = RESP;
                    else if (req_we) state_nxt = ST;
                    else             state_nxt = LD_ADDR;
                end
            end
            LD_ADDR: state_nxt = LD_DATA;
            LD_DATA: state_nxt = RESP;
            ST:      state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request capture: only the load path needs funct3 and the byte offset later
    always_ff @(posedge clk) begin
        if (accept) begin
            funct3_q <= req_funct3;
            ofs_q    <= req_addr[1:0];
        end
    end

    // Memory-side and response registers; mem_we lives for exactly the ST cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_we     <= 4'h0;
            mem_waddr  <= 32'h0;
            mem_raddr  <= 32'h0;
            mem_wdata  <= 32'h0;
            resp_rdata <= 32'h0;
            resp_fault <= 1'b0;
        end else begin
            mem_we <= 4'h0;
            if (accept) begin
                mem_raddr <= {req_addr[31:2], 2'b00};
                if (req_we && !req_fault) begin
                    mem_we    <= store_be(req_funct3[1:0], req_addr[1:0]);
                    mem_waddr <= {req_addr[31:2], 2'b00};
                    mem_wdata <= store_data(req_funct3[1:0], req_wdata);
                end
            end
            if (state == LD_DATA) begin
                resp_rdata <= load_extract(funct3_q, ofs_q, mem_rdata);
                resp_fault <= 1'b0;
            end else if (state == ST) begin
                resp_rdata <= 32'h0;
                resp_fault <= 1'b0;
            end else if (accept && req_fault) begin
                resp_rdata <= 32'h0;
                resp_fault <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Scoreboard bench for lsu_mem_port: a byte-array reference model predicts each
// response and store bus cycle; a negedge monitor compares what the DUT presents.
module tb_lsu_mem_port;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic [3:0]  mem_we;
    logic [31:0] mem_waddr;
    logic [31:0] mem_raddr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    lsu_mem_port dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_raddr(mem_raddr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        fault;
        logic [31:0] rdata;
        int          lat;
        logic [3:0]  we;
        logic [31:0] waddr;
        logic [31:0] wdata;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        cur;
    logic        active = 1'b0;
    logic        chk_ready = 1'b0;
    int          cyc = 0;
    int          acc_cyc = 0;
    int          low_cnt = 0;
    int          n_chk = 0;
    int          n_pass = 0;

    logic [31:0] ram [0:127];
    logic [7:0]  ref_mem [0:511];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // RAM with one-cycle read latency and byte write enables
    always @(posedge clk) begin
        mem_rdata <= ram[mem_raddr[8:2]];
        for (int i = 0; i < 4; i++)
            if (mem_we[i]) ram[mem_waddr[8:2]][8*i +: 8] <= mem_wdata[8*i +: 8];
    end

    always @(negedge clk) begin
        int d;
        cyc++;
        if (rst) begin
            active    = 1'b0;
            chk_ready = 1'b0;
        end else begin
            if (chk_ready) begin
                chk("ready_after_resp", req_ready, 1'b1);
                chk_ready = 1'b0;
            end
            if (active) begin
                d = cyc - acc_cyc;
                if (!req_ready) low_cnt++;
                if (d == 1 && cur.we != 4'h0) begin
                    chk("mem_we", mem_we, cur.we);
                    chk("mem_waddr", mem_waddr, cur.waddr);
                    chk("mem_wdata", mem_wdata, cur.wdata);
                end else if (mem_we != 4'h0) begin
                    chk("stray_mem_we", mem_we, 4'h0);
                end
                if (resp_valid) begin
                    chk("resp_latency", d, cur.lat);
                    chk("ready_low_cycles", low_cnt, cur.lat);
                    chk("resp_fault", resp_fault, cur.fault);
                    chk("resp_rdata", resp_rdata, cur.rdata);
                    active    = 1'b0;
                    chk_ready = 1'b1;
                end else if (d > 10) begin
                    chk("resp_timeout", d, cur.lat);
                    active = 1'b0;
                end
            end else begin
                if (resp_valid) chk("unexpected_resp_valid", resp_valid, 1'b0);
                if (mem_we != 4'h0) chk("idle_mem_we", mem_we, 4'h0);
            end
            if (req_valid && req_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_accept", 1'b1, 1'b0);
                end else begin
                    cur     = exp_q.pop_front();
                    active  = 1'b1;
                    acc_cyc = cyc;
                    low_cnt = 0;
                end
            end
        end
    end

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd);
        exp_t        e;
        int          size;
        int          a;
        int          n;
        logic [31:0] v;
        size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        a = int'(addr[8:0]);
        e.fault = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (we && f3[2]) ||
                  ((a % size) != 0);
        e.lat   = e.fault ? 1 : (we ? 2 : 3);
        e.rdata = 32'h0;
        e.we    = 4'h0;
        e.waddr = 32'h0;
        e.wdata = 32'h0;
        if (!e.fault && we) begin
            for (int i = 0; i < size; i++) begin
                ref_mem[a + i]     = wd[8*i +: 8];
                e.we[(a % 4) + i]  = 1'b1;
            end
            e.waddr = addr & ~32'h3;
            for (int i = 0; i < 4; i++) e.wdata[8*i +: 8] = wd[8*(i % size) +: 8];
        end else if (!e.fault) begin
            v = 32'h0;
            for (int i = 0; i < size; i++) v[8*i +: 8] = ref_mem[a + i];
            if (!f3[2] && size < 4 && v[8*size - 1])
                for (int i = size; i < 4; i++) v[8*i +: 8] = 8'hFF;
            e.rdata = v;
        end
        exp_q.push_back(e);

        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        n = 0;
        forever begin
            @(negedge clk);
            if (req_ready) break;
            n++;
            if (n > 50) begin
                chk("accept_timeout", n, 0);
                break;
            end
        end
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        req_we     = 1'($urandom);
        req_funct3 = 3'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_req_ready"}, req_ready, 1'b1);
        chk({tag, "_resp_valid"}, resp_valid, 1'b0);
        chk({tag, "_resp_rdata"}, resp_rdata, 32'h0);
        chk({tag, "_resp_fault"}, resp_fault, 1'b0);
        chk({tag, "_mem_we"}, mem_we, 4'h0);
        chk({tag, "_mem_waddr"}, mem_waddr, 32'h0);
        chk({tag, "_mem_raddr"}, mem_raddr, 32'h0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0]  f3tab [10];
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] v;
        int          k;
        f3tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd6, 3'd3};
        for (int w = 0; w < 128; w++) begin
            v = $urandom;
            ram[w] = v;
            for (int b = 0; b < 4; b++) ref_mem[4*w + b] = v[8*b +: 8];
        end

        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'h0; req_wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_values("por");
        rst = 1'b0;
        @(posedge clk);
        #1;

        issue(1'b1, 3'b010, 32'h100, 32'hDEADBEEF);
        issue(1'b0, 3'b010, 32'h100, 32'h0);
        issue(1'b1, 3'b000, 32'h103, 32'h000000A5);
        issue(1'b0, 3'b000, 32'h103, 32'h0);
        issue(1'b0, 3'b100, 32'h103, 32'h0);
        issue(1'b1, 3'b001, 32'h102, 32'h00008001);
        issue(1'b0, 3'b001, 32'h102, 32'h0);
        issue(1'b0, 3'b101, 32'h102, 32'h0);
        issue(1'b0, 3'b010, 32'h101, 32'h0);
        issue(1'b1, 3'b001, 32'h001, 32'h1234);
        issue(1'b1, 3'b100, 32'h010, 32'h55);
        issue(1'b0, 3'b111, 32'h020, 32'h0);

        // Load dropped by an asynchronous reset landing in the RAM-wait cycle
        issue(1'b0, 3'b010, 32'h100, 32'h0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk_reset_values("midrst");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("post_reset_ready", req_ready, 1'b1);

        for (int t = 0; t < 200; t++) begin
            f3   = f3tab[$urandom_range(0, 9)];
            addr = 32'($urandom_range(0, 511));
            if ($urandom_range(0, 4) != 0)
                addr = addr & ~((f3[1:0] == 2'd0) ? 32'h0 : (f3[1:0] == 2'd1) ? 32'h1 : 32'h3);
            issue(1'($urandom), f3, addr, $urandom);
        end

        k = 0;
        while ((active || exp_q.size() != 0) && k < 50) begin
            @(posedge clk);
            k++;
        end
        repeat (3) @(posedge clk);
        chk("drain_queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
